// File: rtl/matrix_mem_pkg.sv
// rtl/matrix_mem_pkg.sv - shared types, defaults and width helper for the matrix bank
// Contents: command opcodes, FSM states, default geometry, clog2_min1().
package matrix_mem_pkg;

  localparam int DEF_N_MAT  = 3;
  localparam int DEF_ROWS   = 3;
  localparam int DEF_COLS   = 3;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    OP_WRITE     = 2'b00,
    OP_READ      = 2'b01,
    OP_READ_MAT  = 2'b10,
    OP_CLEAR_MAT = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BURST = 2'b01,
    ST_CLEAR = 2'b10
  } state_e;

  // Index width that never collapses to zero bits for single-element ranges.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/matrix_mem_bank_if.sv
// rtl/matrix_mem_bank_if.sv - command/response bundle of the matrix bank
// Signals: cmd_valid/cmd_ready/cmd_op/mat_sel/row/col/wr_data (request),
//          rd_data/rd_valid/rd_last/rd_err/busy (response).
// Modports: master (requester side), slave (bank side).
interface matrix_mem_bank_if
  import matrix_mem_pkg::*;
#(
  parameter int N_MAT  = DEF_N_MAT,
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int DATA_W = DEF_DATA_W
) ();

  localparam int MAT_W = clog2_min1(N_MAT);
  localparam int ROW_W = clog2_min1(ROWS);
  localparam int COL_W = clog2_min1(COLS);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [MAT_W-1:0]  mat_sel;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_last;
  logic              rd_err;
  logic              busy;

  modport master (
    output cmd_valid, cmd_op, mat_sel, row, col, wr_data,
    input  cmd_ready, rd_data, rd_valid, rd_last, rd_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, mat_sel, row, col, wr_data,
    output cmd_ready, rd_data, rd_valid, rd_last, rd_err, busy
  );

endinterface

// File: rtl/matrix_addr_seq.sv
// rtl/matrix_addr_seq.sv - row-major row/col walker shared by burst read and clear
// Ports: clk, reset_n, i_start (sweep begins this cycle at entry 0),
//        i_adv (step past current entry), o_row/o_col (current entry),
//        o_last (current entry is the final one of the matrix).
module matrix_addr_seq
  import matrix_mem_pkg::*;
#(
  parameter  int ROWS  = DEF_ROWS,
  parameter  int COLS  = DEF_COLS,
  localparam int ROW_W = clog2_min1(ROWS),
  localparam int COL_W = clog2_min1(COLS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_start,
  input  logic             i_adv,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col,
  output logic             o_last
);

  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic             w_row_end;
  logic             w_col_end;

  // A start presents entry 0 combinationally so the first entry is handled on
  // the accepting edge itself; the registers then already point at entry 1.
  assign o_row     = i_start ? '0 : r_row;
  assign o_col     = i_start ? '0 : r_col;
  assign w_row_end = (32'(o_row) == 32'(ROWS - 1));
  assign w_col_end = (32'(o_col) == 32'(COLS - 1));
  assign o_last    = w_row_end && w_col_end;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_start || i_adv) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : o_row + ROW_W'(1);
      end else begin
        r_col <= o_col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/matrix_mem_bank.sv
// rtl/matrix_mem_bank.sv - N_MAT x ROWS x COLS storage bank with burst read and clear
// Ports: clk, reset_n (async, active-low), bus (matrix_mem_bank_if.slave):
//        single-cycle command handshake, registered read beats, error pulse, busy.
module matrix_mem_bank
  import matrix_mem_pkg::*;
#(
  parameter int N_MAT  = DEF_N_MAT,
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic              clk,
  input logic              reset_n,
  matrix_mem_bank_if.slave bus
);

  localparam int DEPTH  = N_MAT * ROWS * COLS;
  localparam int MAT_W  = clog2_min1(N_MAT);
  localparam int ROW_W  = clog2_min1(ROWS);
  localparam int COL_W  = clog2_min1(COLS);
  localparam int ADDR_W = clog2_min1(DEPTH);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [MAT_W-1:0]  r_mat;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_rd_last;
  logic              r_rd_err;

  cmd_op_e           w_op;
  logic              w_accept;
  logic              w_mat_ok;
  logic              w_rc_ok;
  logic              w_is_mat_op;
  logic              w_in_range;
  logic [MAT_W-1:0]  w_seq_mat;
  logic [ROW_W-1:0]  w_seq_row;
  logic [COL_W-1:0]  w_seq_col;
  logic              w_seq_last;
  logic              w_seq_start;
  logic              w_seq_adv;
  logic [ADDR_W-1:0] w_cmd_addr;
  logic [ADDR_W-1:0] w_seq_addr;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [DATA_W-1:0] w_wr_val;
  logic              w_do_write;
  logic              w_do_rd;
  logic              w_rd_last;
  logic              w_err;

  function automatic logic [ADDR_W-1:0] flat_addr(input logic [MAT_W-1:0] m,
                                                  input logic [ROW_W-1:0] r,
                                                  input logic [COL_W-1:0] c);
    return ADDR_W'((32'(m) * 32'(ROWS) + 32'(r)) * 32'(COLS) + 32'(c));
  endfunction

  assign w_op        = cmd_op_e'(bus.cmd_op);
  assign w_accept    = bus.cmd_valid && bus.cmd_ready;
  assign w_mat_ok    = (32'(bus.mat_sel) < 32'(N_MAT));
  assign w_rc_ok     = (32'(bus.row) < 32'(ROWS)) && (32'(bus.col) < 32'(COLS));
  assign w_is_mat_op = (w_op == OP_READ_MAT) || (w_op == OP_CLEAR_MAT);
  // Whole-matrix commands ignore row/col, so only mat_sel can reject them.
  assign w_in_range  = w_mat_ok && (w_is_mat_op || w_rc_ok);

  // The walker starts on the accepting edge and runs for as long as the FSM is away from IDLE.
  assign w_seq_start = w_accept && w_in_range && w_is_mat_op;
  assign w_seq_adv   = (r_state != ST_IDLE);
  // The matrix register is not loaded until the accepting edge, so entry 0 uses mat_sel directly.
  assign w_seq_mat   = (r_state == ST_IDLE) ? bus.mat_sel : r_mat;
  assign w_cmd_addr  = flat_addr(bus.mat_sel, bus.row, bus.col);
  assign w_seq_addr  = flat_addr(w_seq_mat, w_seq_row, w_seq_col);

  matrix_addr_seq #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_seq (
    .clk     (clk),
    .reset_n (reset_n),
    .i_start (w_seq_start),
    .i_adv   (w_seq_adv),
    .o_row   (w_seq_row),
    .o_col   (w_seq_col),
    .o_last  (w_seq_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_do_write  = 1'b0;
    w_wr_addr   = w_cmd_addr;
    w_wr_val    = bus.wr_data;
    w_do_rd     = 1'b0;
    w_rd_addr   = w_cmd_addr;
    w_rd_last   = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (!w_in_range) begin
            w_err = 1'b1;
          end else begin
            case (w_op)
              OP_WRITE: w_do_write = 1'b1;
              OP_READ: begin
                w_do_rd   = 1'b1;
                w_rd_last = 1'b1;
              end
              OP_READ_MAT: begin
                w_do_rd   = 1'b1;
                w_rd_addr = w_seq_addr;
                w_rd_last = w_seq_last;
                // A single-entry matrix finishes on the accepting edge.
                if (!w_seq_last) w_state_nxt = ST_BURST;
              end
              OP_CLEAR_MAT: begin
                w_do_write = 1'b1;
                w_wr_addr  = w_seq_addr;
                w_wr_val   = '0;
                if (!w_seq_last) w_state_nxt = ST_CLEAR;
              end
              default: ;
            endcase
          end
        end
      end
      ST_BURST: begin
        w_do_rd   = 1'b1;
        w_rd_addr = w_seq_addr;
        w_rd_last = w_seq_last;
        if (w_seq_last) w_state_nxt = ST_IDLE;
      end
      ST_CLEAR: begin
        w_do_write = 1'b1;
        w_wr_addr  = w_seq_addr;
        w_wr_val   = '0;
        if (w_seq_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mat      <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_accept) r_mat <= bus.mat_sel;
      if (w_do_write) r_mem[w_wr_addr] <= w_wr_val;
      r_rd_valid <= w_do_rd;
      r_rd_last  <= w_do_rd && w_rd_last;
      r_rd_err   <= w_err;
      r_rd_data  <= w_do_rd ? r_mem[w_rd_addr] : '0;
    end
  end

  // Ready is derived from state so a burst's last-beat cycle can accept the next command.
  assign bus.cmd_ready = (r_state == ST_IDLE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.rd_data   = r_rd_data;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_last   = r_rd_last;
  assign bus.rd_err    = r_rd_err;

endmodule

// File: doc/matrix_mem_bank.md
# matrix_mem_bank

Parametrised matrix storage bank holding N_MAT matrices of ROWS x COLS entries with DATA_W-bit data. It is the generalised successor of the fixed 3x3x3 store. Each access is a single command handshake, and the bank adds three capabilities: row-major burst read of a whole matrix, per-matrix clear, and out-of-range error reporting. It sits between the matrix-operation controller (multiplier/adder datapath) and the UART/switch loading front end.

## Interface
- N_MAT, 3, number of matrices (>=1)
- ROWS, 3, rows per matrix (>=1)
- COLS, 3, columns per matrix (>=1)
- DATA_W, 8, entry width in bits
- Derived widths, each with a minimum of 1: MAT_W = $clog2(N_MAT), ROW_W = $clog2(ROWS), COL_W = $clog2(COLS)

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  bank can accept a command; equals ~busy
- cmd_op  in  2  operation code
  - 00 WRITE
  - 01 READ
  - 10 READ_MAT (burst read)
  - 11 CLEAR_MAT
- mat_sel  in  MAT_W  matrix index
- row  in  ROW_W  row index (WRITE/READ only)
- col  in  COL_W  column index (WRITE/READ only)
- wr_data  in  DATA_W  write data
- rd_data  out  DATA_W  read data; forced to 0 whenever rd_valid is low
- rd_valid  out  1  rd_data holds a valid beat
- rd_last  out  1  final beat of a READ or READ_MAT
- rd_err  out  1  one-cycle pulse flagging a rejected command
- busy  out  1  FSM is in BURST or CLEAR

## Operation
- A command is accepted at a rising edge where cmd_valid && cmd_ready. Nothing happens otherwise. cmd_* fields are sampled only at the accepting edge.
- Reset (reset_n=0) drives all outputs to 0 except cmd_ready, which is 1.
  - Every storage entry is cleared to 0.
  - The FSM returns to IDLE and the beat counter to 0.
  - Reset mid-burst or mid-clear aborts the operation immediately; no rd_last is issued.
- FSM states: IDLE, BURST, CLEAR.
  - IDLE -> BURST on an accepted in-range READ_MAT, only when ROWS*COLS>1.
  - IDLE -> CLEAR on an accepted in-range CLEAR_MAT, only when ROWS*COLS>1.
  - BURST/CLEAR -> IDLE after processing the entry at flat index ROWS*COLS-1.
- WRITE: mem[mat_sel][row][col] <= wr_data at the accepting edge.
- READ: one beat with rd_valid=1 and rd_last=1.
- READ_MAT: ROWS*COLS beats in row-major order, flat index k = r*COLS+c.
  - The beat counter starts at 0 and wraps to 0 at the end.
  - rd_last is high on beat ROWS*COLS-1 only.
- CLEAR_MAT: zeroes one entry per cycle in row-major order; rd_valid stays low throughout.
- Range check: mat_sel>=N_MAT, or (for WRITE/READ only) row>=ROWS or col>=COLS, makes the command a rejected command.
  - It is still accepted and memory is unchanged.
  - rd_err pulses for 1 cycle; rd_valid stays low.
  - The FSM stays in IDLE.
- Arithmetic: the flat index counter is $clog2(ROWS*COLS) bits wide (min 1), and the row/col split uses no division. Separate row and col counters with col wrap-around at COLS-1 are the required implementation.

## Timing
- Command accepted at edge T.
- WRITE: data is visible to a READ accepted at edge T+1.
- READ: rd_data is valid in cycle T+1 (1-cycle latency, registered output).
- READ_MAT: beat k appears in cycle T+1+k, for k = 0..ROWS*COLS-1.
  - busy is high in cycles T+1 .. T+ROWS*COLS-1.
  - cmd_ready returns high in the rd_last cycle, so a new command can be accepted at that cycle's ending edge with no bubble.
- CLEAR_MAT: entry k is zeroed at edge T+k.
  - busy has the same window as READ_MAT.
  - A READ accepted at the first edge after busy falls returns 0.
- While busy, cmd_valid is ignored and the command is not consumed. The requester must hold it until cmd_ready is high.
- rd_err is asserted in cycle T+1.
- Simultaneous events:
  - WRITE and READ at the same address cannot collide, because there is one command per edge.
  - A READ_MAT accepted on a burst's last-beat edge starts its beat 0 in the following cycle, keeping the beat stream continuous.

## Structure
- Shared package matrix_mem_pkg holds:
  - the cmd_op enum (OP_WRITE, OP_READ, OP_READ_MAT, OP_CLEAR_MAT)
  - the FSM state enum
  - default parameter constants
- One sub-module, matrix_addr_seq: row/col/last counter with start, advance and wrap. It is used by both BURST and CLEAR.
- Storage is a flat array indexed as (mat*ROWS + row)*COLS + col. No multi-dimensional unpacked arrays.

## Test plan
- Reset then READ (mat 2, row 2, col 2) -> rd_valid=1, rd_last=1, rd_data=0x00 in cycle T+1; cmd_ready=1 during and after reset.
- WRITE 0x11..0x19 to matrix 1 row-major, then READ_MAT mat 1 -> beats 0x11..0x19 in 9 consecutive cycles, rd_last only on 0x19, busy high for 8 cycles.
- CLEAR_MAT mat 1 issued right after a READ_MAT, cmd_valid held high -> CLEAR accepted in the rd_last cycle; following READ_MAT mat 1 returns nine 0x00 beats; matrices 0 and 2 are unchanged.
- Out-of-range commands: WRITE row=3 and READ mat_sel=3 (defaults) -> rd_err pulse each, rd_valid=0, memory unchanged.
- reset_n pulsed low during beat 4 of a burst -> outputs 0 asynchronously, no rd_last, all entries 0 afterwards.
- Parameter sweep N_MAT=4, ROWS=2, COLS=5, DATA_W=16 -> 10-beat bursts with correct row-major order; 1x1 case completes in one beat with no BURST state.
